// File: rtl/frame_draw_scheduler_if.sv
// Object, sprite-ROM and framebuffer signals shared between the frame draw
// scheduler (master) and the objects, sprite ROM and framebuffer around it (slave).
interface frame_draw_scheduler_if #(
  parameter int NUM_OBJ = 4,
  parameter int COLOR_W = 4
);
  logic [8:0]           PixelX;
  logic [8:0]           PixelY;
  logic [NUM_OBJ-1:0]   obj_hit;
  logic [16*NUM_OBJ-1:0] obj_addr;
  logic [15:0]          rom_addr;
  logic                 rom_ce;
  logic [COLOR_W-1:0]   rom_data;
  logic                 fb_we;
  logic [16:0]          fb_addr;
  logic [COLOR_W-1:0]   fb_data;
  logic                 fb_ready;

  modport master (
    output PixelX, PixelY, rom_addr, rom_ce, fb_we, fb_addr, fb_data,
    input  obj_hit, obj_addr, rom_data, fb_ready
  );

  modport slave (
    input  PixelX, PixelY, rom_addr, rom_ce, fb_we, fb_addr, fb_data,
    output obj_hit, obj_addr, rom_data, fb_ready
  );
endinterface

// File: rtl/frame_draw_scheduler.sv
// Raster-scans the framebuffer once per frame_clk edge, arbitrates sprite hits by
// fixed priority, fetches the winner's ROM pixel and writes the colour index out.
module frame_draw_scheduler #(
  parameter int NUM_OBJ = 4,
  parameter int H_PIX   = 320,
  parameter int V_PIX   = 240,
  parameter int ROM_LAT = 2,
  parameter int COLOR_W = 4,
  parameter logic [COLOR_W-1:0] TRANSPARENT = '0,
  parameter logic [COLOR_W-1:0] BG_INDEX    = '0
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  frame_draw_scheduler_if.master bus,
  output logic busy,
  output logic frame_done,
  output logic overrun
);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  localparam logic [8:0]  X_LAST   = 9'(H_PIX - 1);
  localparam logic [8:0]  Y_LAST   = 9'(V_PIX - 1);
  localparam logic [16:0] LINE_LEN = 17'(H_PIX);

  state_t state;
  logic   prev_frame_clk;
  logic   frame_edge;
  logic   stall;
  logic   pipe_valid;
  logic   last_accept;
  logic   any_hit;
  logic [15:0] win_addr;
  logic [16:0] pix_addr;

  logic        valid_a;
  logic        hit_a;
  logic [16:0] addr_a;
  logic [ROM_LAT-1:0]        d_valid;
  logic [ROM_LAT-1:0]        d_hit;
  logic [ROM_LAT-1:0][16:0]  d_addr;

  assign frame_edge  = frame_clk & ~prev_frame_clk;
  assign stall       = bus.fb_we & ~bus.fb_ready;
  assign pipe_valid  = valid_a | (|d_valid);
  assign last_accept = (state == DRAIN) & bus.fb_we & bus.fb_ready & ~pipe_valid;
  assign bus.rom_ce  = ~stall & (pipe_valid | (state == SCAN));
  assign any_hit     = |bus.obj_hit;
  assign pix_addr    = 17'(bus.PixelY) * LINE_LEN + 17'(bus.PixelX);

  // Lowest index wins, so scan from the lowest priority upwards and let later hits override.
  always_comb begin
    win_addr = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (bus.obj_hit[i]) win_addr = bus.obj_addr[16*i +: 16];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= IDLE;
      prev_frame_clk <= 1'b1;
      bus.PixelX     <= '0;
      bus.PixelY     <= '0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      prev_frame_clk <= frame_clk;
      frame_done     <= 1'b0;
      // The frame_done cycle still belongs to the finished frame, so an edge there is an overrun.
      if (frame_edge && (state != IDLE || frame_done)) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (frame_edge && !frame_done) begin
            state      <= SCAN;
            busy       <= 1'b1;
            bus.PixelX <= '0;
            bus.PixelY <= '0;
          end
        end
        SCAN: begin
          if (!stall) begin
            if (bus.PixelX == X_LAST && bus.PixelY == Y_LAST) begin
              state <= DRAIN;
            end else if (bus.PixelX == X_LAST) begin
              bus.PixelX <= '0;
              bus.PixelY <= bus.PixelY + 9'd1;
            end else begin
              bus.PixelX <= bus.PixelX + 9'd1;
            end
          end
        end
        DRAIN: begin
          if (last_accept) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Hit flag and pixel address ride a delay line that advances with rom_ce, so they
  // stay aligned with rom_data however the ROM pipeline is stalled.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bus.rom_addr <= '0;
      valid_a      <= 1'b0;
      hit_a        <= 1'b0;
      addr_a       <= '0;
      d_valid      <= '0;
      d_hit        <= '0;
      d_addr       <= '0;
      bus.fb_we    <= 1'b0;
      bus.fb_addr  <= '0;
      bus.fb_data  <= '0;
    end else begin
      if (!stall) begin
        valid_a      <= (state == SCAN);
        hit_a        <= (state == SCAN) && any_hit;
        bus.rom_addr <= ((state == SCAN) && any_hit) ? win_addr : 16'd0;
        addr_a       <= pix_addr;
        bus.fb_we    <= bus.rom_ce & d_valid[ROM_LAT-1];
        bus.fb_addr  <= d_addr[ROM_LAT-1];
        bus.fb_data  <= (d_hit[ROM_LAT-1] && bus.rom_data != TRANSPARENT) ? bus.rom_data
                                                                          : BG_INDEX;
      end
      if (bus.rom_ce) begin
        for (int k = ROM_LAT - 1; k > 0; k--) begin
          d_valid[k] <= d_valid[k-1];
          d_hit[k]   <= d_hit[k-1];
          d_addr[k]  <= d_addr[k-1];
        end
        d_valid[0] <= valid_a;
        d_hit[0]   <= hit_a;
        d_addr[0]  <= addr_a;
      end
    end
  end
endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Randomized frame-level bench: objects, sprite ROM and framebuffer are modelled here
// and every write is compared against a per-pixel priority/transparency model.
module tb_frame_draw_scheduler;
  localparam int NUM_OBJ = 4;
  localparam int H_PIX   = 40;
  localparam int V_PIX   = 30;
  localparam int ROM_LAT = 2;
  localparam int COLOR_W = 4;
  localparam int NPIX    = H_PIX * V_PIX;
  localparam int BUDGET  = 12 * NPIX;

  logic Clk = 1'b0;
  logic Reset;
  logic frame_clk;
  logic busy;
  logic frame_done;
  logic overrun;

  frame_draw_scheduler_if #(.NUM_OBJ(NUM_OBJ), .COLOR_W(COLOR_W)) bus ();

  frame_draw_scheduler #(
    .NUM_OBJ(NUM_OBJ), .H_PIX(H_PIX), .V_PIX(V_PIX), .ROM_LAT(ROM_LAT),
    .COLOR_W(COLOR_W), .TRANSPARENT(4'd0), .BG_INDEX(4'd0)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .bus(bus),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #10 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Scene: one random rectangle per object plus optional fixed priority/transparency pixels.
  bit          scene_on;
  bit          directed_on;
  int          scene_gen = 0;
  int          rx0[NUM_OBJ];
  int          ry0[NUM_OBJ];
  int          rw[NUM_OBJ];
  int          rh[NUM_OBJ];
  logic [15:0] rbase[NUM_OBJ];

  function automatic bit obj_hits(int i, int x, int y);
    if (!scene_on) return 1'b0;
    if (directed_on) begin
      if (i == 0 && ((x == 10 && y == 20) || (x == 5 && y == 5))) return 1'b1;
      if (i == 1 && (((x == 10 || x == 11) && y == 20) || (x == 5 && y == 5))) return 1'b1;
    end
    return (x >= rx0[i] && x < rx0[i] + rw[i] && y >= ry0[i] && y < ry0[i] + rh[i]);
  endfunction

  function automatic logic [15:0] obj_address(int i, int x, int y);
    if (directed_on) begin
      if (i == 0 && x == 10 && y == 20) return 16'h0100;
      if (i == 0 && x == 5 && y == 5)   return 16'h030F;
      if (i == 1 && y == 20 && (x == 10 || x == 11)) return 16'h0200;
      if (i == 1 && x == 5 && y == 5)   return 16'h0021;
    end
    return 16'(int'(rbase[i]) + (y - ry0[i]) * rw[i] + (x - rx0[i]));
  endfunction

  function automatic logic [3:0] rom_value(logic [15:0] a);
    logic [15:0] s;
    s = a + 16'd1;
    return s[3:0];
  endfunction

  function automatic logic [15:0] model_rom_addr(int x, int y);
    for (int i = 0; i < NUM_OBJ; i++)
      if (obj_hits(i, x, y)) return obj_address(i, x, y);
    return 16'h0000;
  endfunction

  function automatic logic [3:0] model_color(int x, int y);
    for (int i = 0; i < NUM_OBJ; i++)
      if (obj_hits(i, x, y)) return rom_value(obj_address(i, x, y));
    return 4'd0;
  endfunction

  always @(bus.PixelX or bus.PixelY or scene_gen) begin
    for (int i = 0; i < NUM_OBJ; i++) begin
      bus.obj_hit[i]          = obj_hits(i, int'(bus.PixelX), int'(bus.PixelY));
      bus.obj_addr[16*i +: 16] = obj_address(i, int'(bus.PixelX), int'(bus.PixelY));
    end
  end

  // Sprite ROM with ROM_LAT clock-enabled stages.
  logic [3:0] rom_s[ROM_LAT];
  initial for (int k = 0; k < ROM_LAT; k++) rom_s[k] = 4'd0;
  assign bus.rom_data = rom_s[ROM_LAT-1];
  always @(posedge Clk) begin
    if (bus.rom_ce) begin
      rom_s[0] <= rom_value(bus.rom_addr);
      for (int k = 1; k < ROM_LAT; k++) rom_s[k] <= rom_s[k-1];
    end
  end

  // Framebuffer-side monitor, sampled on the falling edge.
  int          wr_count, addr_errs, data_errs, hold_errs, rce_errs, radr_errs;
  int          first_we_cyc, last_acc_cyc, done_count, done_cyc, edge_cyc;
  bit          last_done, pend_radr;
  bit          pend_prio;
  logic [15:0] exp_radr;
  logic [15:0] prio_radr;
  logic [3:0]  got[NPIX];
  logic        prev_stall = 1'b0;
  logic        prev_we;
  logic [16:0] prev_addr;
  logic [3:0]  prev_data;

  task automatic clear_monitor();
    wr_count = 0; addr_errs = 0; data_errs = 0; hold_errs = 0; rce_errs = 0;
    radr_errs = 0; first_we_cyc = -1; last_acc_cyc = -1; done_count = 0;
    done_cyc = -1; last_done = 0; pend_radr = 0; pend_prio = 0;
    prio_radr = 16'hFFFF;
    for (int p = 0; p < NPIX; p++) got[p] = 4'hF;
  endtask

  always @(negedge Clk) begin
    logic stall_now;
    logic [3:0] exp_c;
    if (Reset) begin
      prev_stall = 1'b0;
      pend_radr  = 0;
      pend_prio  = 0;
    end else begin
      stall_now = bus.fb_we && !bus.fb_ready;
      if (prev_stall && (bus.fb_we !== prev_we || bus.fb_addr !== prev_addr ||
                         bus.fb_data !== prev_data)) hold_errs++;
      if (stall_now && bus.rom_ce !== 1'b0) rce_errs++;
      if (pend_radr && bus.rom_addr !== exp_radr) radr_errs++;
      if (pend_prio) prio_radr = bus.rom_addr;
      pend_radr = 0;
      pend_prio = 0;
      if (busy && !last_done && !stall_now) begin
        exp_radr  = model_rom_addr(int'(bus.PixelX), int'(bus.PixelY));
        pend_radr = 1;
        pend_prio = directed_on && bus.PixelX == 9'd10 && bus.PixelY == 9'd20;
        if (int'(bus.PixelX) == H_PIX - 1 && int'(bus.PixelY) == V_PIX - 1) last_done = 1;
      end
      if (bus.fb_we && first_we_cyc < 0) first_we_cyc = cyc;
      if (bus.fb_we && bus.fb_ready) begin
        if (wr_count < NPIX) begin
          if (bus.fb_addr !== 17'(wr_count)) addr_errs++;
          exp_c = model_color(wr_count % H_PIX, wr_count / H_PIX);
          if (bus.fb_data !== exp_c) data_errs++;
          got[wr_count] = bus.fb_data;
        end
        wr_count++;
        last_acc_cyc = cyc;
      end
      if (frame_done) begin
        done_count++;
        done_cyc = cyc;
      end
      prev_stall = stall_now;
      prev_we    = bus.fb_we;
      prev_addr  = bus.fb_addr;
      prev_data  = bus.fb_data;
    end
  end

  // fb_ready: always ready, or a 7-cycle hold at the third write followed by random toggling.
  bit bp_mode = 0;
  bit bp_held = 0;
  initial begin
    bus.fb_ready = 1'b1;
    forever begin
      @(posedge Clk);
      #1;
      if (bp_mode) begin
        if (!bp_held && bus.fb_we && wr_count == 2) begin
          bp_held      = 1;
          bus.fb_ready = 1'b0;
          repeat (7) @(posedge Clk);
          #1;
          bus.fb_ready = 1'b1;
        end else if (bp_held) begin
          bus.fb_ready = 1'($urandom_range(0, 1));
        end
      end else begin
        bus.fb_ready = 1'b1;
      end
    end
  end

  task automatic new_scene(input bit on, input bit directed);
    scene_on    = on;
    directed_on = directed;
    for (int i = 0; i < NUM_OBJ; i++) begin
      rx0[i]   = $urandom_range(0, H_PIX - 1);
      ry0[i]   = directed ? $urandom_range(22, V_PIX - 1) : $urandom_range(0, V_PIX - 1);
      rw[i]    = $urandom_range(1, 12);
      rh[i]    = $urandom_range(1, 10);
      rbase[i] = 16'($urandom);
    end
    scene_gen++;
  endtask

  task automatic raise_edge(input bit record);
    @(posedge Clk);
    #1;
    frame_clk = 1'b1;
    if (record) edge_cyc = cyc;
    repeat (3) @(posedge Clk);
    #1;
    frame_clk = 1'b0;
  endtask

  // One full frame: scene setup, start edge, optional overrun edge, wait and check.
  task automatic applyStimulus(input string name, input bit on, input bit directed,
                               input bit bp, input int overrun_at, input bit edge_at_done);
    new_scene(on, directed);
    clear_monitor();
    bp_held = 0;
    bp_mode = bp;
    raise_edge(1);
    if (overrun_at > 0) begin
      repeat (overrun_at - 5) @(posedge Clk);
      raise_edge(0);
      #1;
      checkOutput({name, "_overrun_set"}, overrun, 1);
      checkOutput({name, "_busy_through_overrun"}, busy, 1);
    end
    if (edge_at_done) begin
      for (int i = 0; i < BUDGET && wr_count < NPIX; i++) @(posedge Clk);
      #1;
      frame_clk = 1'b1;
      repeat (3) @(posedge Clk);
      #1;
      frame_clk = 1'b0;
    end
    for (int i = 0; i < BUDGET && done_count == 0; i++) @(posedge Clk);
    #2;
    checkOutput({name, "_frame_timeout"}, done_count == 0, 0);
    bp_mode = 0;
    repeat (6) @(posedge Clk);
    #2;
    checkOutput({name, "_write_count"}, wr_count, NPIX);
    checkOutput({name, "_addr_errors"}, addr_errs, 0);
    checkOutput({name, "_data_errors"}, data_errs, 0);
    checkOutput({name, "_rom_addr_errors"}, radr_errs, 0);
    checkOutput({name, "_stall_hold_errors"}, hold_errs, 0);
    checkOutput({name, "_stall_rom_ce_errors"}, rce_errs, 0);
    checkOutput({name, "_first_write_latency"}, first_we_cyc - edge_cyc, 5);
    checkOutput({name, "_done_pulses"}, done_count, 1);
    checkOutput({name, "_done_after_last_write"}, done_cyc - last_acc_cyc, 1);
    checkOutput({name, "_busy_after"}, busy, 0);
  endtask

  task automatic check_reset_values(input string name);
    checkOutput({name, "_PixelX"}, bus.PixelX, 0);
    checkOutput({name, "_PixelY"}, bus.PixelY, 0);
    checkOutput({name, "_rom_addr"}, bus.rom_addr, 0);
    checkOutput({name, "_rom_ce"}, bus.rom_ce, 0);
    checkOutput({name, "_fb_we"}, bus.fb_we, 0);
    checkOutput({name, "_fb_addr"}, bus.fb_addr, 0);
    checkOutput({name, "_fb_data"}, bus.fb_data, 0);
    checkOutput({name, "_busy"}, busy, 0);
    checkOutput({name, "_frame_done"}, frame_done, 0);
    checkOutput({name, "_overrun"}, overrun, 0);
  endtask

  initial begin
    Reset     = 1'b1;
    frame_clk = 1'b0;
    new_scene(0, 0);
    clear_monitor();
    repeat (3) @(posedge Clk);
    #2;
    check_reset_values("por");
    #1;
    Reset = 1'b0;
    repeat (3) @(posedge Clk);

    $display("[TB] empty scene");
    applyStimulus("empty", 0, 0, 0, 0, 0);

    $display("[TB] priority and transparency");
    applyStimulus("prio", 1, 1, 0, 0, 0);
    checkOutput("prio_rom_addr", prio_radr, 16'h0100);
    checkOutput("prio_data_10_20", got[20*H_PIX + 10], 1);
    checkOutput("prio_data_11_20", got[20*H_PIX + 11], 1);
    checkOutput("transparent_5_5", got[5*H_PIX + 5], 0);

    $display("[TB] backpressure");
    applyStimulus("bp", 1, 0, 1, 0, 0);

    $display("[TB] overrun");
    checkOutput("overrun_clear_before", overrun, 0);
    applyStimulus("ovr", 1, 0, 0, 1000, 0);
    applyStimulus("after_ovr", 1, 0, 0, 0, 0);
    checkOutput("overrun_sticky", overrun, 1);

    $display("[TB] reset mid-frame");
    new_scene(1, 0);
    clear_monitor();
    raise_edge(1);
    for (int i = 0; i < BUDGET && wr_count < 500; i++) @(posedge Clk);
    checkOutput("rst_reached_pixel_500", wr_count, 500);
    #1;
    Reset     = 1'b1;
    frame_clk = 1'b1;
    @(posedge Clk);
    #2;
    check_reset_values("midrst");
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    clear_monitor();
    repeat (20) @(posedge Clk);
    #2;
    checkOutput("rst_no_writes", wr_count, 0);
    checkOutput("rst_no_fb_we", first_we_cyc, -1);
    checkOutput("rst_high_no_start", busy, 0);
    frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    applyStimulus("post_rst", 1, 0, 0, 0, 0);

    $display("[TB] edge in the frame_done cycle");
    applyStimulus("edge_at_done", 1, 0, 0, 0, 1);
    checkOutput("edge_at_done_overrun", overrun, 1);
    checkOutput("edge_at_done_no_restart", wr_count, NPIX);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
